// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer fronting a bank of DEPTH word-wide
// read/write registers with a configurable number of wait states.
//
// Build option: define APB_SLV_WAIT_EN to compile in the wait-state counter
// (honours WAIT_CYCLES). Left undefined, the slave is zero-wait and
// WAIT_CYCLES has no effect.
//
// Address, direction and error are captured in the setup cycle and held for
// the rest of the transfer. PRDATA/PSLVERR are decoded combinationally from
// that registered state and the storage, so the response shows up in the same
// cycle that PREADY rises.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            err_q, err_d;
    logic                            wr_q, wr_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

    logic addr_err;
    logic setup;
    logic ready;
    logic complete;
    logic commit;

`ifdef APB_SLV_WAIT_EN
    logic [3:0] cnt_q, cnt_d;
`else
    // WAIT_CYCLES is deliberately inert in the zero-wait build.
    logic unused_wait_cfg;
    assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    // Address decode on the live bus: misaligned or beyond the bank is an error.
    always_comb begin
        addr_err = (PADDR[1:0] != 2'b00) || (|PADDR[ADDR_WIDTH-1:IDX_W+2]);
        setup    = PSEL && !PENABLE;
    end

    // Ready is purely a function of registered state; completion needs the
    // master to be in its access phase as well.
`ifdef APB_SLV_WAIT_EN
    assign ready = (state_q == ACCESS) && (cnt_q == 4'd0);
`else
    assign ready = (state_q == ACCESS);
`endif
    assign complete = PSEL && PENABLE && ready;
    assign commit   = complete && wr_q && !err_q;

    // Next-state logic: capture the transfer at setup, count down the wait
    // states, leave on completion or when the master abandons the transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        wr_d    = wr_q;
`ifdef APB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // PENABLE high while idle is a master error and is ignored.
                if (setup) begin
                    state_d = ACCESS;
                    idx_d   = PADDR[IDX_W+1:2];
                    err_d   = addr_err;
                    wr_d    = PWRITE;
`ifdef APB_SLV_WAIT_EN
                    cnt_d   = 4'(WAIT_CYCLES);
`endif
                end
            end
            ACCESS: begin
                if (!PSEL || complete) begin
                    state_d = IDLE;
`ifdef APB_SLV_WAIT_EN
                    cnt_d   = 4'd0;
`endif
                end
`ifdef APB_SLV_WAIT_EN
                else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage update: a write lands only on a clean completion.
    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[idx_q] = PWDATA;
        end
    end

    // Response decode: data only on a clean read, error flag only with ready.
    always_comb begin
        PREADY  = ready;
        PSLVERR = ready && err_q;
        PRDATA  = '0;
        if (ready && !wr_q && !err_q) begin
            PRDATA = regs_q[idx_q];
        end
    end

    // Control state; reset abandons any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end
    end

`ifdef APB_SLV_WAIT_EN
    // Wait-state counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Register bank.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed + randomized bench for apb_slave_regfile. A plain array holds the
// expected register contents; the expected response of each transfer is
// derived from the address rules and that array.
module tb_apb_slave_regfile;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int WAITS = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = WAITS;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] ref_mem [DEPTH];

    apb_slave_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .PADDR  (PADDR),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PWDATA (PWDATA),
        .PREADY (PREADY),
        .PRDATA (PRDATA),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One full transfer, starting just after a clock edge. Returns with the
    // bus released one step after the completion edge, so two consecutive
    // calls are back-to-back with no idle cycle.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] data);
        bit            err;
        logic [DW-1:0] exp_rd;
        int            waits;
        err    = (addr % 4 != 0) || (addr >= DEPTH * 4);
        exp_rd = (!wr && !err) ? ref_mem[addr / 4] : '0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = data;
        tick();
        PENABLE = 1'b1;
        waits = 0;
        while (!PREADY && waits < 40) begin
            chk("wait_pslverr", {31'd0, PSLVERR}, 32'd0);
            tick();
            waits++;
        end
        chk("wait_states", waits, EXP_WAIT);
        chk("pslverr", {31'd0, PSLVERR}, {31'd0, err});
        chk("prdata", PRDATA, exp_rd);
        tick();
        if (wr && !err) ref_mem[addr / 4] = data;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        chk("ready_after_done", {31'd0, PREADY}, 32'd0);
    endtask

    initial begin
        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        repeat (3) tick();
        PRESETn = 1'b1;
        tick();

        // Reset state on an idle bus, then every index reads back zero.
        chk("rst_pready", {31'd0, PREADY}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        for (int i = 0; i < DEPTH; i++) xfer(AW'(i * 4), 1'b0, '0);

        // Basic write then read.
        xfer(32'h08, 1'b1, 32'hDEADBEEF);
        tick();
        xfer(32'h08, 1'b0, '0);

        // Out-of-range and misaligned accesses error and leave storage alone.
        xfer(32'h40, 1'b1, 32'h12345678);
        xfer(32'h06, 1'b1, 32'h87654321);
        xfer(32'h40, 1'b0, '0);
        xfer(32'h06, 1'b0, '0);
        xfer(32'h04, 1'b0, '0);
        xfer(32'h08, 1'b0, '0);

        // Back-to-back write then read with no idle cycle between them.
        tick();
        xfer(32'h00, 1'b1, 32'h11);
        xfer(32'h00, 1'b0, '0);

        // Abandoned write: master drops PSEL in the first access cycle.
        xfer(32'h04, 1'b1, 32'hCAFE0004);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 32'h04;
        PWRITE  = 1'b1;
        PWDATA  = 32'h55;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        tick();
        chk("abort_idle", {31'd0, PREADY}, 32'd0);
        tick();
        xfer(32'h04, 1'b0, '0);

        // PENABLE asserted while idle must not start or complete a transfer.
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PADDR   = 32'h08;
        PWRITE  = 1'b1;
        PWDATA  = 32'h0BAD0BAD;
        tick();
        chk("idle_penable", {31'd0, PREADY}, 32'd0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        tick();
        xfer(32'h08, 1'b0, '0);

        // Randomized traffic, including some error addresses and idle gaps.
        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, DEPTH * 4 + 15));
            if ($urandom_range(0, 3) != 0) a = {a[AW-1:2], 2'b00};
            xfer(a, 1'($urandom_range(0, 1)), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset asserted in the middle of a write.
        xfer(32'h0C, 1'b1, 32'hA5A5A5A5);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 32'h0C;
        PWRITE  = 1'b1;
        PWDATA  = 32'h5A5A5A5A;
        tick();
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        chk("midrst_pready", {31'd0, PREADY}, 32'd0);
        chk("midrst_prdata", PRDATA, 32'd0);
        chk("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        tick();
        tick();
        PRESETn = 1'b1;
        tick();
        chk("postrst_idle", {31'd0, PREADY}, 32'd0);
        xfer(32'h0C, 1'b0, '0);
        xfer(32'h08, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
